// File: rtl/mips_sim_pkg.sv
// Shared types and default constants for the MIPS run monitor and its bench hex images.
package mips_sim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RD    = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } mon_state_t;

  localparam logic [31:0] DEFAULT_END_PC     = 32'h0000_007C;
  localparam int unsigned DEFAULT_DUMP_BASE  = 32;
  localparam int unsigned DEFAULT_DUMP_WORDS = 96;

endpackage

// File: rtl/mips_run_monitor_if.sv
// Signal bundle between the run monitor and its environment: core fetch, dmem read port, dump stream.
interface mips_run_monitor_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 32
);
  import mips_sim_pkg::*;

  logic          start;
  logic [AW-1:0] pc_f;
  logic          pc_valid;
  logic          core_halt;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          dump_valid;
  logic          dump_ready;
  logic [DW-1:0] dump_data;
  logic [15:0]   dump_idx;
  logic          dump_eol;
  logic          running;
  logic          done;
  logic          timed_out;
  logic [CW-1:0] cycle_count;
  mon_state_t    dbg_state;

  // Dump stream: a word moves on the clock edge where dump_valid && dump_ready are both high;
  // while dump_valid is high and dump_ready low, dump_data/dump_idx/dump_eol do not change.
  modport slave (
    input  start, pc_f, pc_valid, mem_rd_data, dump_ready,
    output core_halt, mem_rd_en, mem_rd_addr, dump_valid, dump_data, dump_idx, dump_eol,
           running, done, timed_out, cycle_count, dbg_state
  );

  modport master (
    output start, pc_f, pc_valid, mem_rd_data, dump_ready,
    input  core_halt, mem_rd_en, mem_rd_addr, dump_valid, dump_data, dump_idx, dump_eol,
           running, done, timed_out, cycle_count, dbg_state
  );

endinterface

// File: rtl/mips_end_detect.sv
// Program-end detection: consecutive END_PC fetch counter plus the RUN cycle-limit compare.
module mips_end_detect #(
  parameter int unsigned     AW        = 32,
  parameter int unsigned     CW        = 32,
  parameter logic [AW-1:0]   END_PC    = 32'h7C,
  parameter int unsigned     HIT_COUNT = 2,
  parameter int unsigned     TIMEOUT   = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          run_i,
  input  logic [AW-1:0] pc_f_i,
  input  logic          pc_valid_i,
  input  logic [CW-1:0] cycle_count_i,
  output logic          end_hit_o,
  output logic          end_timeout_o
);

  localparam logic [3:0]  HIT_TGT = 4'(HIT_COUNT);
  localparam logic [CW:0] TO_VAL  = (CW+1)'(TIMEOUT);
  localparam bit          TO_EN   = (TIMEOUT != 0);

  logic [3:0] hit_q, hit_d;
  logic       pc_match;

  assign pc_match = pc_valid_i && (pc_f_i == END_PC);

  // Stalled fetches hold the count; any other valid fetch breaks the run of hits.
  always_comb begin
    hit_d = hit_q;
    if (clear_i) begin
      hit_d = '0;
    end else if (run_i && pc_valid_i) begin
      hit_d = pc_match ? (hit_q + 4'd1) : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign end_hit_o     = run_i && pc_match && ((hit_q + 4'd1) == HIT_TGT);
  assign end_timeout_o = run_i && TO_EN && (({1'b0, cycle_count_i} + (CW+1)'(1)) == TO_VAL);

endmodule

// File: rtl/mips_run_monitor.sv
// Run controller for the pipelined MIPS core: detects program end, halts the core, drains, then dumps dmem.
module mips_run_monitor
  import mips_sim_pkg::*;
#(
  parameter int unsigned   AW           = 32,
  parameter int unsigned   DW           = 32,
  parameter logic [AW-1:0] END_PC       = AW'(DEFAULT_END_PC),
  parameter int unsigned   HIT_COUNT    = 2,
  parameter int unsigned   DRAIN_CYCLES = 4,
  parameter int unsigned   DUMP_BASE    = DEFAULT_DUMP_BASE,
  parameter int unsigned   DUMP_WORDS   = DEFAULT_DUMP_WORDS,
  parameter int unsigned   LINE_WORDS   = 16,
  parameter int unsigned   TIMEOUT      = 65535,
  parameter int unsigned   CW           = 32
) (
  input  logic             clk,
  input  logic             reset,
  mips_run_monitor_if.slave bus
);

  localparam logic [15:0] DRAIN_LAST = 16'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
  localparam logic [15:0] LAST_IDX   = 16'(DUMP_WORDS - 1);
  localparam logic [15:0] LINE_LAST  = 16'(LINE_WORDS - 1);

  mon_state_t    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          halt_q, halt_d;
  logic          to_q, to_d;
  logic [15:0]   ptr_q, ptr_d;
  logic [15:0]   col_q, col_d;
  logic [15:0]   drain_q, drain_d;
  logic          first_q, first_d;
  logic [DW-1:0] word_q, word_d;

  logic start_ok, run_w, end_hit, end_timeout;

  assign start_ok = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign run_w    = (state_q == ST_RUN);

  mips_end_detect #(
    .AW(AW), .CW(CW), .END_PC(END_PC), .HIT_COUNT(HIT_COUNT), .TIMEOUT(TIMEOUT)
  ) u_end_detect (
    .clk(clk),
    .reset(reset),
    .clear_i(start_ok),
    .run_i(run_w),
    .pc_f_i(bus.pc_f),
    .pc_valid_i(bus.pc_valid),
    .cycle_count_i(cyc_q),
    .end_hit_o(end_hit),
    .end_timeout_o(end_timeout)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    halt_d  = halt_q;
    to_d    = to_q;
    ptr_d   = ptr_q;
    col_d   = col_q;
    drain_d = drain_q;
    first_d = 1'b0;
    word_d  = word_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          cyc_d   = '0;
          halt_d  = 1'b0;
          to_d    = 1'b0;
          ptr_d   = '0;
          col_d   = '0;
        end
      end
      ST_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CW'(1);
        // A genuine END_PC hit wins over a coincident timeout.
        if (end_hit || end_timeout) begin
          state_d = ST_DRAIN;
          halt_d  = 1'b1;
          to_d    = !end_hit;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_RD;
          ptr_d   = '0;
          col_d   = '0;
        end else begin
          drain_d = drain_q + 16'd1;
        end
      end
      ST_RD: begin
        state_d = ST_OUT;
        first_d = 1'b1;
      end
      ST_OUT: begin
        if (first_q) word_d = bus.mem_rd_data;
        if (bus.dump_ready) begin
          if (ptr_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD;
            ptr_d   = ptr_q + 16'd1;
            col_d   = (col_q == LINE_LAST) ? 16'd0 : (col_q + 16'd1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      halt_q  <= 1'b0;
      to_q    <= 1'b0;
      ptr_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
      first_q <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      halt_q  <= halt_d;
      to_q    <= to_d;
      ptr_q   <= ptr_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      first_q <= first_d;
      word_q  <= word_d;
    end
  end

  // The read data is only on the bus during the first OUT cycle; later cycles replay the capture.
  assign bus.dump_data   = first_q ? bus.mem_rd_data : word_q;
  assign bus.dump_valid  = (state_q == ST_OUT);
  assign bus.dump_idx    = ptr_q;
  assign bus.dump_eol    = (state_q == ST_OUT) && ((col_q == LINE_LAST) || (ptr_q == LAST_IDX));
  assign bus.mem_rd_en   = (state_q == ST_RD);
  assign bus.mem_rd_addr = (state_q == ST_RD) ? (AW'(DUMP_BASE) + AW'(ptr_q)) : '0;
  assign bus.core_halt   = halt_q;
  assign bus.running     = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.timed_out   = to_q;
  assign bus.cycle_count = cyc_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Bench for mips_run_monitor: end detection, timeout, drain timing and the dump stream under back-pressure.
module tb_mips_run_monitor;
  import mips_sim_pkg::*;

  localparam int HIT    = 2;
  localparam int DRAIN  = 4;
  localparam int BASE   = 32;
  localparam int LINE   = 16;
  localparam int A_WORDS = 96;
  localparam int B_WORDS = 4;
  localparam int A_TO   = 65535;
  localparam int B_TO   = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_run_monitor_if #(.AW(32), .DW(32), .CW(32)) ifa ();
  mips_run_monitor_if #(.AW(32), .DW(32), .CW(32)) ifb ();

  mips_run_monitor #(.TIMEOUT(A_TO), .DUMP_WORDS(A_WORDS)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa.slave)
  );
  mips_run_monitor #(.TIMEOUT(B_TO), .DUMP_WORDS(B_WORDS)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb.slave)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hA000_0000 + addr;
  endfunction

  // Data memory: 1-cycle read latency, garbage on the bus when not reading.
  always @(posedge clk) begin
    if (ifa.mem_rd_en) ifa.mem_rd_data <= mem_word(ifa.mem_rd_addr);
    else               ifa.mem_rd_data <= $urandom;
    if (ifb.mem_rd_en) ifb.mem_rd_data <= mem_word(ifb.mem_rd_addr);
    else               ifb.mem_rd_data <= $urandom;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prog_pc[$];
  bit          prog_v[$];

  typedef struct packed {
    logic        running, done, halt, to, valid, eol, rd_en;
    logic [31:0] cyc, data, rd_addr;
    logic [15:0] idx;
    mon_state_t  st;
  } snap_t;

  function automatic snap_t snap(input bit sel);
    snap_t s;
    if (sel) s = '{ifb.running, ifb.done, ifb.core_halt, ifb.timed_out, ifb.dump_valid, ifb.dump_eol,
                   ifb.mem_rd_en, ifb.cycle_count, ifb.dump_data, ifb.mem_rd_addr, ifb.dump_idx, ifb.dbg_state};
    else     s = '{ifa.running, ifa.done, ifa.core_halt, ifa.timed_out, ifa.dump_valid, ifa.dump_eol,
                   ifa.mem_rd_en, ifa.cycle_count, ifa.dump_data, ifa.mem_rd_addr, ifa.dump_idx, ifa.dbg_state};
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_pc(input bit sel, input logic [31:0] pc, input logic v);
    if (sel) begin ifb.pc_f = pc; ifb.pc_valid = v; end
    else     begin ifa.pc_f = pc; ifa.pc_valid = v; end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) ifb.start = v; else ifa.start = v;
  endtask

  task automatic set_ready(input bit sel, input logic v);
    if (sel) ifb.dump_ready = v; else ifa.dump_ready = v;
  endtask

  task automatic prog_add(input logic [31:0] pc, input bit v);
    prog_pc.push_back(pc);
    prog_v.push_back(v);
  endtask

  // Reference: index of the RUN cycle in which the run ends, and whether it ended by timeout.
  function automatic int model_end(input int timeout, output bit to);
    int hits = 0;
    to = 1'b0;
    for (int k = 0; k < prog_pc.size(); k++) begin
      if (prog_v[k]) hits = (prog_pc[k] == DEFAULT_END_PC) ? hits + 1 : 0;
      if (hits == HIT) return k;
      if (timeout != 0 && k + 1 == timeout) begin
        to = 1'b1;
        return k;
      end
    end
    return -1;
  endfunction

  task automatic check_zero(input bit sel, input string tag);
    snap_t s = snap(sel);
    check({tag, "_running"}, s.running, 0);
    check({tag, "_done"}, s.done, 0);
    check({tag, "_halt"}, s.halt, 0);
    check({tag, "_timed_out"}, s.to, 0);
    check({tag, "_valid"}, s.valid, 0);
    check({tag, "_eol"}, s.eol, 0);
    check({tag, "_rd_en"}, s.rd_en, 0);
    check({tag, "_rd_addr"}, s.rd_addr, 0);
    check({tag, "_cycle_count"}, s.cyc, 0);
    check({tag, "_data"}, s.data, 0);
    check({tag, "_idx"}, s.idx, 0);
    check({tag, "_state"}, s.st, ST_IDLE);
  endtask

  // Starts a run, feeds the program, and checks the end cycle, halt timing and end cause.
  task automatic run_check(input bit sel, input string tag);
    snap_t s;
    bit exp_to;
    int e = model_end(sel ? B_TO : A_TO, exp_to);
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    for (int k = 0; k <= e; k++) begin
      if (k > 0) @(negedge clk);
      s = snap(sel);
      check({tag, "_running"}, s.running, 1);
      check({tag, "_halt_low"}, s.halt, 0);
      check({tag, "_cycle_count"}, s.cyc, k);
      if (k == 0) check({tag, "_timed_out_clear"}, s.to, 0);
      drive_pc(sel, prog_pc[k], prog_v[k]);
    end
    @(negedge clk);
    drive_pc(sel, 32'h0, 1'b0);
    s = snap(sel);
    check({tag, "_end_running"}, s.running, 0);
    check({tag, "_end_halt"}, s.halt, 1);
    check({tag, "_end_cycles"}, s.cyc, e + 1);
    check({tag, "_end_timed_out"}, s.to, exp_to);
    check({tag, "_end_state"}, s.st, ST_DRAIN);
  endtask

  // Consumes the dump; called on the first DRAIN cycle. abort_idx >= 0 asserts reset at that word.
  task automatic dump_check(input bit sel, input string tag, input bit rand_ready, input int abort_idx);
    int words = sel ? B_WORDS : A_WORDS;
    int accepted = 0;
    int n = 0;
    bit held = 1'b0;
    bit ready;
    snap_t s, prev;
    exp_q.delete();
    for (int i = 0; i < words; i++) exp_q.push_back(mem_word(32'(BASE + i)));
    set_ready(sel, 1'b1);
    prev = snap(sel);
    s = prev;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      s = snap(sel);
      if (s.done) break;
      if (held) begin
        check({tag, "_hold_valid"}, s.valid, 1);
        check({tag, "_hold_data"}, s.data, prev.data);
        check({tag, "_hold_idx"}, s.idx, prev.idx);
        check({tag, "_hold_eol"}, s.eol, prev.eol);
      end
      if (s.rd_en) check({tag, "_rd_addr"}, s.rd_addr, BASE + accepted);
      if (s.valid && abort_idx >= 0 && int'(s.idx) == abort_idx) begin
        rst = 1'b1;
        @(negedge clk);
        check_zero(sel, {tag, "_abort"});
        rst = 1'b0;
        return;
      end
      ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      set_ready(sel, ready);
      held = s.valid && !ready;
      prev = s;
      if (s.valid && ready) begin
        check({tag, "_data"}, s.data, exp_q.pop_front());
        check({tag, "_idx"}, s.idx, accepted);
        check({tag, "_eol"}, s.eol, ((accepted + 1) % LINE == 0) || (accepted == words - 1));
        accepted++;
      end
    end
    check({tag, "_done"}, s.done, 1);
    check({tag, "_done_halt"}, s.halt, 1);
    check({tag, "_done_state"}, s.st, ST_DONE);
    check({tag, "_word_count"}, accepted, words);
    if (!rand_ready) check({tag, "_dump_cycles"}, n, DRAIN + 2 * words);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ifa.start = 0; ifa.pc_f = 0; ifa.pc_valid = 0; ifa.dump_ready = 0;
    ifb.start = 0; ifb.pc_f = 0; ifb.pc_valid = 0; ifb.dump_ready = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(1'b0, "reset_a");
    check_zero(1'b1, "reset_b");
    rst = 1'b0;

    // Straight-line program ending on two END_PC fetches, full-speed dump.
    prog_pc.delete(); prog_v.delete();
    for (int a = 0; a <= 32'h78; a += 4) prog_add(32'(a), 1'b1);
    prog_add(32'h7C, 1'b1); prog_add(32'h7C, 1'b1);
    run_check(1'b0, "t1_run");
    dump_check(1'b0, "t4_dump", 1'b0, -1);

    // Stalls between hits hold the count.
    prog_pc.delete(); prog_v.delete();
    prog_add(32'h7C, 1'b1); prog_add(32'h7C, 1'b0); prog_add(32'h00, 1'b0);
    prog_add(32'h7C, 1'b0); prog_add(32'h7C, 1'b1);
    run_check(1'b0, "t2_stall");
    dump_check(1'b0, "t5_bp", 1'b1, -1);

    // Timeout on the small instance, then END_PC coinciding with the timeout cycle.
    prog_pc.delete(); prog_v.delete();
    for (int k = 0; k < 25; k++) prog_add(32'(k * 4), 1'b1);
    run_check(1'b1, "t3_timeout");
    dump_check(1'b1, "t3_dump", 1'b0, -1);
    prog_pc.delete(); prog_v.delete();
    for (int k = 0; k < 18; k++) prog_add(32'(k * 4), 1'b1);
    prog_add(32'h7C, 1'b1); prog_add(32'h7C, 1'b1);
    run_check(1'b1, "t3_coincide");
    dump_check(1'b1, "t3_dump2", 1'b1, -1);

    // Non-END fetch between hits resets the count; reset mid-dump at word 40.
    prog_pc.delete(); prog_v.delete();
    prog_add(32'h7C, 1'b1); prog_add(32'h80, 1'b1); prog_add(32'h7C, 1'b1); prog_add(32'h7C, 1'b1);
    run_check(1'b0, "t2_break");
    dump_check(1'b0, "t6_abort", 1'b1, 40);

    // Fresh random program after reset must dump from word 0 again.
    prog_pc.delete(); prog_v.delete();
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       prog_add(32'h7C, $urandom_range(0, 3) != 0);
        1:       prog_add(32'h80, $urandom_range(0, 3) != 0);
        default: prog_add(32'($urandom_range(0, 31) * 4), $urandom_range(0, 3) != 0);
      endcase
    end
    prog_add(32'h7C, 1'b1); prog_add(32'h7C, 1'b1);
    run_check(1'b0, "t6_rand_run");
    dump_check(1'b0, "t6_rand_dump", 1'b1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
